// File: rtl/mac_pkg.sv
// Shared datapath sizes for the systolic input path: beat and tile widths.
package mac_pkg;

   localparam int unsigned BEAT_WIDTH     = 64;
   localparam int unsigned TILE_WIDTH     = 512;
   localparam int unsigned BEATS_PER_TILE = 8;
   localparam int unsigned BEAT_IDX_W     = $clog2(BEATS_PER_TILE);

   typedef logic [TILE_WIDTH-1:0] tile_t;

endpackage

// File: rtl/tile_buffer.sv
// One 512-bit tile register; each 64-bit beat lane has its own write enable.
module tile_buffer
   import mac_pkg::*;
(
   input  logic                      clk,
   input  logic                      clear,
   input  logic [BEATS_PER_TILE-1:0] wr_en,
   input  logic [BEAT_WIDTH-1:0]     wr_data,
   output tile_t                     data
);

   tile_t data_q;
   tile_t data_d;

   always_comb begin
      data_d = data_q;
      if (clear) begin
         data_d = '0;
      end else begin
         for (int unsigned b = 0; b < BEATS_PER_TILE; b++) begin
            if (wr_en[b]) data_d[b*BEAT_WIDTH +: BEAT_WIDTH] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/input_collector.sv
// Packs 64-bit beats into 512-bit tiles through a ping-pong buffer pair.
// Optional tile handshake counter: define INPUT_COLLECTOR_TILE_CNT_EN.
module input_collector
   import mac_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  src_valid,
   input  logic [BEAT_WIDTH-1:0] src_data,
   output logic                  src_ready,
   input  logic                  abort,
   output logic                  tile_valid,
   output tile_t                 tile_data,
   input  logic                  tile_ready,
   output logic [1:0]            full_count
`ifdef INPUT_COLLECTOR_TILE_CNT_EN
   ,
   output logic [15:0]           tile_cnt
`endif
);

   logic [1:0]            full_q, full_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [BEAT_IDX_W-1:0] beat_cnt_q, beat_cnt_d;
   logic                  src_ready_q, src_ready_d;
   logic                  tile_valid_q, tile_valid_d;
   logic [1:0]            full_count_q, full_count_d;

   logic                      accept_c;
   logic                      last_beat_c;
   logic                      take_c;
   logic [BEATS_PER_TILE-1:0] lane_en_c;
   tile_t                     buf0_data, buf1_data;

   // Abort wins over a same-cycle beat; ready is a registered function of buffer state only.
   assign accept_c    = src_valid & src_ready_q & ~abort;
   assign last_beat_c = accept_c & (beat_cnt_q == BEAT_IDX_W'(BEATS_PER_TILE - 1));
   assign take_c      = tile_valid_q & tile_ready;
   assign lane_en_c   = accept_c ? (BEATS_PER_TILE'(1) << beat_cnt_q) : '0;

   always_comb begin
      full_d     = full_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      beat_cnt_d = beat_cnt_q;

      if (abort) begin
         beat_cnt_d = '0;
      end else if (accept_c) begin
         beat_cnt_d = last_beat_c ? '0 : beat_cnt_q + BEAT_IDX_W'(1);
      end

      if (last_beat_c) begin
         full_d[wr_ptr_q] = 1'b1;
         wr_ptr_d         = ~wr_ptr_q;
      end

      if (take_c) begin
         full_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = ~rd_ptr_q;
      end

      src_ready_d  = ~full_d[wr_ptr_d];
      tile_valid_d = full_d[rd_ptr_d];
      full_count_d = 2'(full_d[0]) + 2'(full_d[1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q       <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         beat_cnt_q   <= '0;
         src_ready_q  <= 1'b1;
         tile_valid_q <= 1'b0;
         full_count_q <= '0;
      end else begin
         full_q       <= full_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         src_ready_q  <= src_ready_d;
         tile_valid_q <= tile_valid_d;
         full_count_q <= full_count_d;
      end
   end

   tile_buffer u_buf0 (
      .clk     (clk),
      .clear   (reset),
      .wr_en   (wr_ptr_q ? '0 : lane_en_c),
      .wr_data (src_data),
      .data    (buf0_data)
   );

   tile_buffer u_buf1 (
      .clk     (clk),
      .clear   (reset),
      .wr_en   (wr_ptr_q ? lane_en_c : '0),
      .wr_data (src_data),
      .data    (buf1_data)
   );

   assign src_ready  = src_ready_q;
   assign tile_valid = tile_valid_q;
   assign full_count = full_count_q;
   assign tile_data  = rd_ptr_q ? buf1_data : buf0_data;

`ifdef INPUT_COLLECTOR_TILE_CNT_EN
   logic [15:0] tile_cnt_q, tile_cnt_d;

   always_comb begin
      tile_cnt_d = tile_cnt_q;
      if (take_c) tile_cnt_d = tile_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) tile_cnt_q <= '0;
      else       tile_cnt_q <= tile_cnt_d;
   end

   assign tile_cnt = tile_cnt_q;
`endif

endmodule

// File: tb/tb_input_collector.sv
// Bench for input_collector: control-output vector table plus a tile scoreboard.
module tb_input_collector;
   import mac_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        src_valid;
   logic [63:0] src_data;
   logic        src_ready;
   logic        abort;
   logic        tile_valid;
   tile_t       tile_data;
   logic        tile_ready;
   logic [1:0]  full_count;
`ifdef INPUT_COLLECTOR_TILE_CNT_EN
   logic [15:0] tile_cnt;
`endif

   input_collector dut (
      .clk        (clk),
      .reset      (reset),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .abort      (abort),
      .tile_valid (tile_valid),
      .tile_data  (tile_data),
      .tile_ready (tile_ready),
      .full_count (full_count)
`ifdef INPUT_COLLECTOR_TILE_CNT_EN
      ,
      .tile_cnt   (tile_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic        v;
      logic [63:0] d;
      logic        a;
      logic        r;
      logic        esr;
      logic        etv;
      logic [1:0]  efc;
   } vec_t;

   vec_t  vecs[$];
   tile_t exp_q[$];
   tile_t model_tile;
   int    model_idx = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic void add(input logic v, input logic [63:0] d, input logic a, input logic r,
                               input logic esr, input logic etv, input logic [1:0] efc);
      vec_t x;
      x = '{v: v, d: d, a: a, r: r, esr: esr, etv: etv, efc: efc};
      vecs.push_back(x);
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are then stable until the next edge.
   task automatic step(input logic v, input logic [63:0] d, input logic a, input logic r);
      src_valid  = v;
      src_data   = d;
      abort      = a;
      tile_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic send_beats(input logic [63:0] base, input int n, input logic r);
      for (int k = 0; k < n; k++) step(1'b1, base + 64'(k), 1'b0, r);
   endtask

   // Scoreboard: assemble accepted beats into expected tiles, compare on each tile handshake.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         model_idx = 0;
      end else begin
         if (tile_valid && tile_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL tile_order: got tile %0h expected no tile", tile_data);
            end else begin
               chk("tile_data", tile_data, exp_q.pop_front());
            end
         end
         if (abort) begin
            model_idx = 0;
         end else if (src_valid && src_ready) begin
            model_tile[model_idx*64 +: 64] = src_data;
            if (model_idx == 7) begin
               exp_q.push_back(model_tile);
               model_idx = 0;
            end else begin
               model_idx++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; src_valid = 1'b0; src_data = '0; abort = 1'b0; tile_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_src_ready",  512'(src_ready),  512'(1));
      chk("rst_tile_valid", 512'(tile_valid), 512'(0));
      chk("rst_full_count", 512'(full_count), 512'(0));
      reset = 1'b0;

      // single tile, loader always ready
      for (int k = 0; k < 7; k++) add(1, 64'(k), 0, 1, 1, 0, 0);
      add(1, 64'h7, 0, 1, 1, 1, 1);
      add(0, 64'h0, 0, 1, 1, 0, 0);
      // backpressure: two tiles fill, third tile's first beat is held
      for (int k = 0; k < 7; k++) add(1, 64'h100 + 64'(k), 0, 0, 1, 0, 0);
      add(1, 64'h107, 0, 0, 1, 1, 1);
      for (int k = 0; k < 7; k++) add(1, 64'h200 + 64'(k), 0, 0, 1, 1, 1);
      add(1, 64'h207, 0, 0, 0, 1, 2);
      add(1, 64'h300, 0, 0, 0, 1, 2);
      add(1, 64'h300, 0, 1, 1, 1, 1);
      add(1, 64'h300, 0, 1, 1, 0, 0);
      for (int k = 1; k < 7; k++) add(1, 64'h300 + 64'(k), 0, 1, 1, 0, 0);
      add(1, 64'h307, 0, 1, 1, 1, 1);
      add(0, 64'h0, 0, 1, 1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].v, vecs[i].d, vecs[i].a, vecs[i].r);
         chk($sformatf("v%0d_src_ready", i),  512'(src_ready),  512'(vecs[i].esr));
         chk($sformatf("v%0d_tile_valid", i), 512'(tile_valid), 512'(vecs[i].etv));
         chk($sformatf("v%0d_full_count", i), 512'(full_count), 512'(vecs[i].efc));
         if (i == 7) begin
            chk("single_lo_beat", 512'(tile_data[63:0]),    512'(0));
            chk("single_hi_beat", 512'(tile_data[511:448]), 512'(7));
         end
      end

      // 8th beat of B lands on the same edge A is taken
      send_beats(64'h400, 8, 1'b0);
      send_beats(64'h500, 7, 1'b0);
      step(1'b1, 64'h507, 1'b0, 1'b1);
      chk("simul_full_count", 512'(full_count), 512'(1));
      chk("simul_tile_valid", 512'(tile_valid), 512'(1));
      chk("simul_src_ready",  512'(src_ready),  512'(1));
      step(1'b0, 64'h0, 1'b0, 1'b1);
      chk("simul_drained", 512'(full_count), 512'(0));

      // abort mid-tile, with a beat offered in the abort cycle
      send_beats(64'hA0, 5, 1'b1);
      step(1'b1, 64'hDEAD, 1'b1, 1'b1);
      send_beats(64'h10, 7, 1'b1);
      chk("abort_no_early_tile", 512'(tile_valid), 512'(0));
      step(1'b1, 64'h17, 1'b0, 1'b1);
      chk("abort_tile_valid", 512'(tile_valid),         512'(1));
      chk("abort_lo_beat",    512'(tile_data[63:0]),    512'(64'h10));
      chk("abort_hi_beat",    512'(tile_data[511:448]), 512'(64'h17));
      step(1'b0, 64'h0, 1'b0, 1'b1);

      // reset with one tile pending and a partial tile in flight
      send_beats(64'h600, 8, 1'b0);
      send_beats(64'h700, 3, 1'b0);
      reset = 1'b1;
      step(1'b0, 64'h0, 1'b0, 1'b0);
      reset = 1'b0;
      chk("mrst_tile_valid", 512'(tile_valid), 512'(0));
      chk("mrst_full_count", 512'(full_count), 512'(0));
      chk("mrst_src_ready",  512'(src_ready),  512'(1));
      step(1'b0, 64'h0, 1'b0, 1'b1);
      chk("mrst_stays_empty", 512'(tile_valid), 512'(0));
      send_beats(64'h800, 7, 1'b0);
      chk("mrst_count_cleared", 512'(tile_valid), 512'(0));
      step(1'b1, 64'h807, 1'b0, 1'b0);
      chk("mrst_fresh_tile", 512'(full_count), 512'(1));
      step(1'b0, 64'h0, 1'b0, 1'b1);

`ifdef INPUT_COLLECTOR_TILE_CNT_EN
      reset = 1'b1;
      step(1'b0, 64'h0, 1'b0, 1'b0);
      reset = 1'b0;
      chk("cnt_reset", 512'(tile_cnt), 512'(0));
      for (int t = 0; t < 3; t++) begin
         send_beats(64'h900 + 64'(t * 16), 8, 1'b1);
         step(1'b0, 64'h0, 1'b0, 1'b1);
      end
      chk("cnt_three", 512'(tile_cnt), 512'(3));
      force dut.tile_cnt_q = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.tile_cnt_q;
      send_beats(64'hB00, 8, 1'b1);
      step(1'b0, 64'h0, 1'b0, 1'b1);
      chk("cnt_wrap", 512'(tile_cnt), 512'(0));
`endif

      step(1'b0, 64'h0, 1'b0, 1'b1);
      chk("sb_empty", 512'(exp_q.size()), 512'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
